// File: rtl/alu_enums_pkg.sv
// Shared decode types: ALU operation encoding, RV32I opcode and funct7
// constants, and the destination-history entry used for hazard tracking.
package alu_enums;

  // ALU operation selected by decode. ALU_NONE marks bubbles and illegal slots.
  typedef enum logic [4:0] {
    ALU_NONE,
    ALU_ADDI,
    ALU_SLTI,
    ALU_SLTIU,
    ALU_XORI,
    ALU_ORI,
    ALU_ANDI,
    ALU_SLLI,
    ALU_SRLI,
    ALU_SRAI,
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_LUI,
    ALU_AUIPC
  } alu_op_t;

  // Major opcodes handled by this stage (inst[6:0]).
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct7 values: base encoding and the alternate (SUB / SRA / SRAI) form.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // One in-flight destination: the register written and whether it is written.
  typedef struct packed {
    logic [4:0] rd;
    logic       wr_en;
  } hist_entry_t;

endpackage

// File: rtl/decode_pipe_unit_rd_history.sv
// In-flight destination history and RAW hazard comparators for both source
// operands. hist[0] mirrors the decode output slot; older entries are the
// instructions already handed to execute, youngest first.
module rd_history
  import alu_enums::*;
#(
  parameter int HAZ_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 shift_en,
  input  logic                 fill_en,
  input  logic                 consume,
  input  hist_entry_t          new_entry,
  input  logic [4:0]           rs1_addr,
  input  logic                 rs1_en,
  input  logic [4:0]           rs2_addr,
  input  logic                 rs2_en,
  output logic [HAZ_DEPTH-1:0] haz_rs1,
  output logic [HAZ_DEPTH-1:0] haz_rs2
);

  hist_entry_t hist  [HAZ_DEPTH];
  hist_entry_t ahead [HAZ_DEPTH];

  // When the slot is consumed, hist[0] is the instruction directly ahead of the
  // new one. When an empty slot is filled without a consume, hist[0] is that
  // empty bubble being replaced, so the view starts one entry further back.
  for (genvar k = 0; k < HAZ_DEPTH; k++) begin : g_ahead
    if (k + 1 < HAZ_DEPTH) begin : g_mid
      assign ahead[k] = consume ? hist[k] : hist[k+1];
    end else begin : g_last
      assign ahead[k] = consume ? hist[k] : '0;
    end
  end

  // Compare both source operands against every older destination.
  always_comb begin
    haz_rs1 = '0;
    haz_rs2 = '0;
    for (int k = 0; k < HAZ_DEPTH; k++) begin
      haz_rs1[k] = rs1_en && ahead[k].wr_en && (ahead[k].rd == rs1_addr);
      haz_rs2[k] = rs2_en && ahead[k].wr_en && (ahead[k].rd == rs2_addr);
    end
  end

  // Shift on consume, overwrite the head when an empty slot fills, clear on flush.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the history is a handful of flops and is reset on purpose; a stale
    // rd left over from before reset would raise false hazards.
    if (!reset_n) begin
      for (int k = 0; k < HAZ_DEPTH; k++) hist[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < HAZ_DEPTH; k++) hist[k] <= '0;
    end else if (shift_en) begin
      hist[0] <= new_entry;
      for (int k = 1; k < HAZ_DEPTH; k++) hist[k] <= hist[k-1];
    end else if (fill_en) begin
      hist[0] <= new_entry;
    end
  end

endmodule

// File: rtl/decode_pipe_unit.sv
// RV32I decode stage: decodes OP-IMM, OP, LUI and AUIPC into one registered
// slot for execute, with a valid/ready handshake, flush, and per-operand
// RAW hazard vectors against the instructions still in flight.
module decode_pipe_unit
  import alu_enums::*;
#(
  parameter int XLEN       = 32,
  parameter int HAZ_DEPTH  = 2,
  parameter int EN_REG_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 if_valid,
  input  logic [31:0]          if_inst,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 id_ready,
  input  logic                 flush,
  input  logic                 ex_ready,
  output logic                 id_valid,
  output logic [XLEN-1:0]      id_pc,
  output logic [4:0]           id_rs1_addr,
  output logic [4:0]           id_rs2_addr,
  output logic [4:0]           id_rd_addr,
  output logic                 id_rs1_en,
  output logic                 id_rs2_en,
  output logic                 id_rd_wr_en,
  output logic [XLEN-1:0]      id_imm,
  output logic                 id_use_imm,
  output logic                 id_use_pc,
  output alu_op_t              id_alu_op,
  output logic                 id_illegal,
  output logic [HAZ_DEPTH-1:0] id_haz_rs1,
  output logic [HAZ_DEPTH-1:0] id_haz_rs2
);

  // Instruction fields.
  logic [6:0] opcode;
  logic [4:0] rd_f, rs1_f, rs2_f;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = if_inst[6:0];
  assign rd_f   = if_inst[11:7];
  assign funct3 = if_inst[14:12];
  assign rs1_f  = if_inst[19:15];
  assign rs2_f  = if_inst[24:20];
  assign funct7 = if_inst[31:25];

  // Immediate formats, extended to XLEN.
  logic [XLEN-1:0] imm_i, imm_sh, imm_u;
  assign imm_i  = XLEN'($signed(if_inst[31:20]));
  assign imm_sh = XLEN'(if_inst[24:20]);
  assign imm_u  = XLEN'($signed({if_inst[31:12], 12'b0}));

  // Decoded view of the incoming instruction.
  alu_op_t         dec_alu;
  logic            dec_illegal;
  logic            rs1_use, rs2_use, rd_use;
  logic [XLEN-1:0] dec_imm;
  logic            dec_use_imm, dec_use_pc;
  logic            dec_rs1_en, dec_rs2_en, dec_rd_wr_en;
  logic [4:0]      dec_rs1_addr, dec_rs2_addr, dec_rd_addr;

  // Opcode/funct decode; anything not recognised falls out as illegal.
  always_comb begin
    // NOTE: every signal this block drives gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    dec_alu     = ALU_NONE;
    dec_illegal = 1'b1;
    rs1_use     = 1'b0;
    rs2_use     = 1'b0;
    rd_use      = 1'b0;
    dec_imm     = '0;
    dec_use_imm = 1'b0;
    dec_use_pc  = 1'b0;

    case (opcode)
      OPC_OP_IMM: begin
        dec_illegal = 1'b0;
        rs1_use     = 1'b1;
        rd_use      = 1'b1;
        dec_use_imm = 1'b1;
        dec_imm     = imm_i;
        case (funct3)
          3'b000: dec_alu = ALU_ADDI;
          3'b010: dec_alu = ALU_SLTI;
          3'b011: dec_alu = ALU_SLTIU;
          3'b100: dec_alu = ALU_XORI;
          3'b110: dec_alu = ALU_ORI;
          3'b111: dec_alu = ALU_ANDI;
          3'b001: begin
            dec_imm = imm_sh;
            if (funct7 == F7_BASE) dec_alu = ALU_SLLI;
            else                   dec_illegal = 1'b1;
          end
          default: begin
            // funct3 101: logical or arithmetic right shift.
            dec_imm = imm_sh;
            if      (funct7 == F7_BASE) dec_alu = ALU_SRLI;
            else if (funct7 == F7_ALT)  dec_alu = ALU_SRAI;
            else                        dec_illegal = 1'b1;
          end
        endcase
      end

      OPC_OP: begin
        if (EN_REG_REG != 0) begin
          dec_illegal = 1'b0;
          rs1_use     = 1'b1;
          rs2_use     = 1'b1;
          rd_use      = 1'b1;
          case ({funct7, funct3})
            {F7_BASE, 3'b000}: dec_alu = ALU_ADD;
            {F7_ALT,  3'b000}: dec_alu = ALU_SUB;
            {F7_BASE, 3'b001}: dec_alu = ALU_SLL;
            {F7_BASE, 3'b010}: dec_alu = ALU_SLT;
            {F7_BASE, 3'b011}: dec_alu = ALU_SLTU;
            {F7_BASE, 3'b100}: dec_alu = ALU_XOR;
            {F7_BASE, 3'b101}: dec_alu = ALU_SRL;
            {F7_ALT,  3'b101}: dec_alu = ALU_SRA;
            {F7_BASE, 3'b110}: dec_alu = ALU_OR;
            {F7_BASE, 3'b111}: dec_alu = ALU_AND;
            default:           dec_illegal = 1'b1;
          endcase
        end
      end

      OPC_LUI: begin
        dec_illegal = 1'b0;
        rd_use      = 1'b1;
        dec_use_imm = 1'b1;
        dec_imm     = imm_u;
        dec_alu     = ALU_LUI;
      end

      OPC_AUIPC: begin
        dec_illegal = 1'b0;
        rd_use      = 1'b1;
        dec_use_imm = 1'b1;
        dec_use_pc  = 1'b1;
        dec_imm     = imm_u;
        dec_alu     = ALU_AUIPC;
      end

      default: ;
    endcase

    // An illegal slot carries no operation, operands or immediate.
    if (dec_illegal) begin
      dec_alu     = ALU_NONE;
      rs1_use     = 1'b0;
      rs2_use     = 1'b0;
      rd_use      = 1'b0;
      dec_imm     = '0;
      dec_use_imm = 1'b0;
      dec_use_pc  = 1'b0;
    end
  end

  // x0 is never a real dependency or destination, so its enables drop and the
  // addresses read as 0 whenever the matching enable is off.
  assign dec_rs1_en   = rs1_use && (rs1_f != 5'd0);
  assign dec_rs2_en   = rs2_use && (rs2_f != 5'd0);
  assign dec_rd_wr_en = rd_use && (rd_f != 5'd0);
  assign dec_rs1_addr = dec_rs1_en   ? rs1_f : 5'd0;
  assign dec_rs2_addr = dec_rs2_en   ? rs2_f : 5'd0;
  assign dec_rd_addr  = dec_rd_wr_en ? rd_f  : 5'd0;

  // Handshake. Flush does not gate ready; it simply discards what arrives.
  logic load, to_bubble;
  assign id_ready  = !id_valid || ex_ready;
  assign load      = if_valid && id_ready && !flush;
  assign to_bubble = flush || (id_ready && !if_valid);

  // History tracking: a consumed slot shifts the history (bubbles push
  // wr_en=0); filling an empty slot while execute is stalled only replaces
  // the head, because nothing moved downstream.
  hist_entry_t                 new_entry;
  logic [HAZ_DEPTH-1:0]        haz_rs1, haz_rs2;
  logic                        hist_shift, hist_fill;

  assign new_entry  = load ? hist_entry_t'{rd: dec_rd_addr, wr_en: dec_rd_wr_en} : '0;
  assign hist_shift = !flush && id_ready && ex_ready;
  assign hist_fill  = load && !ex_ready;

  rd_history #(
    .HAZ_DEPTH (HAZ_DEPTH)
  ) u_rd_history (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .shift_en  (hist_shift),
    .fill_en   (hist_fill),
    .consume   (ex_ready),
    .new_entry (new_entry),
    .rs1_addr  (dec_rs1_addr),
    .rs1_en    (dec_rs1_en),
    .rs2_addr  (dec_rs2_addr),
    .rs2_en    (dec_rs2_en),
    .haz_rs1   (haz_rs1),
    .haz_rs2   (haz_rs2)
  );

  // Output slot: load a decoded instruction, drop to a bubble, or hold on stall.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!reset_n) begin
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_rs1_addr <= '0;
      id_rs2_addr <= '0;
      id_rd_addr  <= '0;
      id_rs1_en   <= 1'b0;
      id_rs2_en   <= 1'b0;
      id_rd_wr_en <= 1'b0;
      id_imm      <= '0;
      id_use_imm  <= 1'b0;
      id_use_pc   <= 1'b0;
      id_alu_op   <= ALU_NONE;
      id_illegal  <= 1'b0;
      id_haz_rs1  <= '0;
      id_haz_rs2  <= '0;
    end else if (to_bubble) begin
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_rs1_addr <= '0;
      id_rs2_addr <= '0;
      id_rd_addr  <= '0;
      id_rs1_en   <= 1'b0;
      id_rs2_en   <= 1'b0;
      id_rd_wr_en <= 1'b0;
      id_imm      <= '0;
      id_use_imm  <= 1'b0;
      id_use_pc   <= 1'b0;
      id_alu_op   <= ALU_NONE;
      id_illegal  <= 1'b0;
      id_haz_rs1  <= '0;
      id_haz_rs2  <= '0;
    end else if (load) begin
      id_valid    <= 1'b1;
      id_pc       <= if_pc;
      id_rs1_addr <= dec_rs1_addr;
      id_rs2_addr <= dec_rs2_addr;
      id_rd_addr  <= dec_rd_addr;
      id_rs1_en   <= dec_rs1_en;
      id_rs2_en   <= dec_rs2_en;
      id_rd_wr_en <= dec_rd_wr_en;
      id_imm      <= dec_imm;
      id_use_imm  <= dec_use_imm;
      id_use_pc   <= dec_use_pc;
      id_alu_op   <= dec_alu;
      id_illegal  <= dec_illegal;
      id_haz_rs1  <= haz_rs1;
      id_haz_rs2  <= haz_rs2;
    end
  end

endmodule

// File: tb/tb_decode_pipe_unit.sv
// Directed testbench for decode_pipe_unit: decode of each instruction class,
// hazard vectors, stall, flush, bubbles and reset, plus an instance with the
// register-register opcode disabled.
module tb_decode_pipe_unit;
  import alu_enums::*;

  localparam int XLEN      = 32;
  localparam int HAZ_DEPTH = 2;

  logic            clk      = 1'b0;
  logic            reset_n  = 1'b1;
  logic            if_valid = 1'b0;
  logic [31:0]     if_inst  = '0;
  logic [XLEN-1:0] if_pc    = '0;
  logic            flush    = 1'b0;
  logic            ex_ready = 1'b1;

  logic                 id_ready, id_valid;
  logic [XLEN-1:0]      id_pc, id_imm;
  logic [4:0]           id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic                 id_rs1_en, id_rs2_en, id_rd_wr_en;
  logic                 id_use_imm, id_use_pc, id_illegal;
  alu_op_t              id_alu_op;
  logic [HAZ_DEPTH-1:0] id_haz_rs1, id_haz_rs2;

  logic                 nr_ready, nr_valid;
  logic [XLEN-1:0]      nr_pc, nr_imm;
  logic [4:0]           nr_rs1_addr, nr_rs2_addr, nr_rd_addr;
  logic                 nr_rs1_en, nr_rs2_en, nr_rd_wr_en;
  logic                 nr_use_imm, nr_use_pc, nr_illegal;
  alu_op_t              nr_alu_op;
  logic [HAZ_DEPTH-1:0] nr_haz_rs1, nr_haz_rs2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_pipe_unit #(
    .XLEN (XLEN), .HAZ_DEPTH (HAZ_DEPTH), .EN_REG_REG (1)
  ) u_dut (
    .clk (clk), .reset_n (reset_n), .if_valid (if_valid), .if_inst (if_inst),
    .if_pc (if_pc), .id_ready (id_ready), .flush (flush), .ex_ready (ex_ready),
    .id_valid (id_valid), .id_pc (id_pc), .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr), .id_rd_addr (id_rd_addr), .id_rs1_en (id_rs1_en),
    .id_rs2_en (id_rs2_en), .id_rd_wr_en (id_rd_wr_en), .id_imm (id_imm),
    .id_use_imm (id_use_imm), .id_use_pc (id_use_pc), .id_alu_op (id_alu_op),
    .id_illegal (id_illegal), .id_haz_rs1 (id_haz_rs1), .id_haz_rs2 (id_haz_rs2)
  );

  decode_pipe_unit #(
    .XLEN (XLEN), .HAZ_DEPTH (HAZ_DEPTH), .EN_REG_REG (0)
  ) u_dut_norr (
    .clk (clk), .reset_n (reset_n), .if_valid (if_valid), .if_inst (if_inst),
    .if_pc (if_pc), .id_ready (nr_ready), .flush (flush), .ex_ready (ex_ready),
    .id_valid (nr_valid), .id_pc (nr_pc), .id_rs1_addr (nr_rs1_addr),
    .id_rs2_addr (nr_rs2_addr), .id_rd_addr (nr_rd_addr), .id_rs1_en (nr_rs1_en),
    .id_rs2_en (nr_rs2_en), .id_rd_wr_en (nr_rd_wr_en), .id_imm (nr_imm),
    .id_use_imm (nr_use_imm), .id_use_pc (nr_use_pc), .id_alu_op (nr_alu_op),
    .id_illegal (nr_illegal), .id_haz_rs1 (nr_haz_rs1), .id_haz_rs2 (nr_haz_rs2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    if_valid = v;
    if_inst  = inst;
    if_pc    = pc;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) tick();
    check("rst_valid", id_valid, 0);
    check("rst_alu", id_alu_op, ALU_NONE);
    check("rst_imm", id_imm, 0);
    check("rst_wr_en", id_rd_wr_en, 0);
    check("rst_haz1", id_haz_rs1, 0);
    check("rst_ready", id_ready, 1);
    reset_n = 1'b1;

    // ADDI x1,x0,-1
    drive(1, 32'hFFF00093, 32'h100);
    tick();
    check("addi_valid", id_valid, 1);
    check("addi_alu", id_alu_op, ALU_ADDI);
    check("addi_imm", id_imm, 32'hFFFF_FFFF);
    check("addi_rd", id_rd_addr, 1);
    check("addi_wr_en", id_rd_wr_en, 1);
    check("addi_rs1_en", id_rs1_en, 0);
    check("addi_use_imm", id_use_imm, 1);
    check("addi_pc", id_pc, 32'h100);

    // Consume with nothing fetched: slot becomes a bubble.
    drive(0, 32'h0, 32'h0);
    tick();
    check("bubble_valid", id_valid, 0);

    // ADDI x1,x0,5 then ADD x2,x1,x1 back to back.
    drive(1, 32'h00500093, 32'h104);
    tick();
    check("addi5_haz1", id_haz_rs1, 0);
    drive(1, 32'h00108133, 32'h108);
    tick();
    check("add_alu", id_alu_op, ALU_ADD);
    check("add_rs1", id_rs1_addr, 1);
    check("add_rs2", id_rs2_addr, 1);
    check("add_rs2_en", id_rs2_en, 1);
    check("add_rd", id_rd_addr, 2);
    check("add_use_imm", id_use_imm, 0);
    check("add_haz1", id_haz_rs1, 2'b01);
    check("add_haz2", id_haz_rs2, 2'b01);
    check("norr_illegal", nr_illegal, 1);
    check("norr_valid", nr_valid, 1);
    check("norr_alu", nr_alu_op, ALU_NONE);
    check("norr_rs1_en", nr_rs1_en, 0);

    // ADDI x1,x0,5 ; NOP ; ADD x2,x1,x1 -> distance two.
    drive(1, 32'h00500093, 32'h10C);
    tick();
    drive(1, 32'h00000013, 32'h110);
    tick();
    check("nop_wr_en", id_rd_wr_en, 0);
    check("nop_rs1_en", id_rs1_en, 0);
    drive(1, 32'h00108133, 32'h114);
    tick();
    check("add_gap_haz1", id_haz_rs1, 2'b10);
    check("add_gap_haz2", id_haz_rs2, 2'b10);

    // SUB x10,x1,x2: x2 is written by the slot just consumed.
    drive(1, 32'h40208533, 32'h118);
    tick();
    check("sub_alu", id_alu_op, ALU_SUB);
    check("sub_rs2", id_rs2_addr, 2);
    check("sub_rd", id_rd_addr, 10);
    check("sub_haz1", id_haz_rs1, 2'b00);
    check("sub_haz2", id_haz_rs2, 2'b01);

    // SRAI x3,x4,7
    drive(1, 32'h40725193, 32'h11C);
    tick();
    check("srai_alu", id_alu_op, ALU_SRAI);
    check("srai_imm", id_imm, 7);
    check("srai_rs1", id_rs1_addr, 4);
    check("srai_rs1_en", id_rs1_en, 1);
    check("srai_rd", id_rd_addr, 3);

    // Same shift with funct7 0100001 is illegal.
    drive(1, 32'h42725193, 32'h120);
    tick();
    check("ill_valid", id_valid, 1);
    check("ill_flag", id_illegal, 1);
    check("ill_alu", id_alu_op, ALU_NONE);
    check("ill_rs1_en", id_rs1_en, 0);
    check("ill_wr_en", id_rd_wr_en, 0);
    check("ill_imm", id_imm, 0);

    // LUI x7,0x80000
    drive(1, 32'h800003B7, 32'h200);
    tick();
    check("lui_alu", id_alu_op, ALU_LUI);
    check("lui_imm", id_imm, 32'h8000_0000);
    check("lui_rs1_en", id_rs1_en, 0);
    check("lui_rd", id_rd_addr, 7);
    check("lui_use_pc", id_use_pc, 0);
    check("lui_illegal", id_illegal, 0);

    // AUIPC x8,0x12345
    drive(1, 32'h12345417, 32'h204);
    tick();
    check("auipc_alu", id_alu_op, ALU_AUIPC);
    check("auipc_use_pc", id_use_pc, 1);
    check("auipc_imm", id_imm, 32'h1234_5000);
    check("auipc_pc", id_pc, 32'h204);

    // Stall: ADDI x6,x0,9 held for three cycles while ORI x9,x6,3 waits.
    drive(1, 32'h00900313, 32'h300);
    tick();
    check("stall_a_imm", id_imm, 9);
    ex_ready = 1'b0;
    drive(1, 32'h00336493, 32'h304);
    #1;
    check("stall_ready", id_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_valid", id_valid, 1);
      check("stall_hold_pc", id_pc, 32'h300);
      check("stall_hold_imm", id_imm, 9);
      check("stall_hold_ready", id_ready, 0);
    end
    ex_ready = 1'b1;
    #1;
    check("release_ready", id_ready, 1);
    tick();
    check("release_pc", id_pc, 32'h304);
    check("release_alu", id_alu_op, ALU_ORI);
    check("release_imm", id_imm, 3);
    check("release_haz1", id_haz_rs1, 2'b01);
    check("release_haz2", id_haz_rs2, 2'b00);

    // Flush during a stall, then ADD x5,x1,x1 sees no hazards.
    drive(1, 32'h00500093, 32'h400);
    tick();
    ex_ready = 1'b0;
    drive(1, 32'h001082B3, 32'h404);
    tick();
    check("pre_flush_pc", id_pc, 32'h400);
    flush = 1'b1;
    tick();
    check("flush_valid", id_valid, 0);
    flush    = 1'b0;
    ex_ready = 1'b1;
    drive(1, 32'h001082B3, 32'h408);
    tick();
    check("post_flush_valid", id_valid, 1);
    check("post_flush_rd", id_rd_addr, 5);
    check("post_flush_haz1", id_haz_rs1, 0);
    check("post_flush_haz2", id_haz_rs2, 0);

    // Reset in the middle of a stall.
    drive(1, 32'h00500093, 32'h500);
    tick();
    ex_ready = 1'b0;
    drive(1, 32'h001082B3, 32'h504);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_valid", id_valid, 0);
    check("midrst_alu", id_alu_op, ALU_NONE);
    check("midrst_pc", id_pc, 0);
    check("midrst_rd", id_rd_addr, 0);
    #2 reset_n = 1'b1;
    ex_ready = 1'b1;
    drive(1, 32'h001082B3, 32'h508);
    tick();
    check("afterrst_valid", id_valid, 1);
    check("afterrst_pc", id_pc, 32'h508);
    check("afterrst_haz1", id_haz_rs1, 0);
    check("afterrst_haz2", id_haz_rs2, 0);

    drive(0, 32'h0, 32'h0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
